// File: rtl/periph_pkg.sv
// Shared constants and types for the peripheral bridge: port count, peripheral
// base pages (addr[31:12]) and the bridge FSM state encoding.
package periph_pkg;

  localparam int unsigned N_SLAVES_DEF = 4;
  localparam int unsigned MAX_SLAVES   = 8;

  localparam logic [19:0] TIMER32_BASE = 20'h00021;
  localparam logic [19:0] GPIO_BASE    = 20'h00022;
  localparam logic [19:0] UART_BASE    = 20'h00023;
  localparam logic [19:0] SPI_BASE     = 20'h00024;
  localparam logic [19:0] AUX0_BASE    = 20'h00025;
  localparam logic [19:0] AUX1_BASE    = 20'h00026;
  localparam logic [19:0] AUX2_BASE    = 20'h00027;
  localparam logic [19:0] AUX3_BASE    = 20'h00028;

  // Port i occupies bits [i*20 +: 20]; port 0 is the least significant slot.
  localparam logic [MAX_SLAVES*20-1:0] SLV_BASE_DEF = {
    AUX3_BASE, AUX2_BASE, AUX1_BASE, AUX0_BASE,
    SPI_BASE,  UART_BASE, GPIO_BASE, TIMER32_BASE
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DERR,
    ST_ERESP
  } state_t;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational page decoder: matches addr[31:12] against each port base,
// lowest-numbered matching port wins.
module periph_addr_decode
  import periph_pkg::*;
#(
  parameter int unsigned                N_SLAVES = N_SLAVES_DEF,
  parameter logic [MAX_SLAVES*20-1:0]   SLV_BASE = SLV_BASE_DEF
) (
  input  logic [31:12] addr,
  output logic         hit,
  output logic [2:0]   sel
);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!hit && (addr == SLV_BASE[i*20 +: 20])) begin
        hit = 1'b1;
        sel = 3'(i);
      end
    end
  end

endmodule

// File: rtl/periph_bridge.sv
// Single-outstanding bridge from one master port to N_SLAVES peripheral ports,
// with decode errors and a per-phase wait timeout turned into error responses.
module periph_bridge
  import periph_pkg::*;
#(
  parameter int unsigned              N_SLAVES = N_SLAVES_DEF,
  parameter logic [MAX_SLAVES*20-1:0] SLV_BASE = SLV_BASE_DEF,
  parameter logic [7:0]               TIMEOUT  = 8'd255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [3:0]               m_be,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic                     m_gnt,
  output logic                     m_rvalid,
  output logic                     m_err,
  output logic [31:0]              m_rdata,
  output logic [N_SLAVES-1:0]      s_req,
  output logic                     s_we,
  output logic [3:0]               s_be,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [N_SLAVES-1:0]      s_gnt,
  input  logic [N_SLAVES-1:0]      s_rvalid,
  input  logic [N_SLAVES*32-1:0]   s_rdata
);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [2:0]  sel_q;
  logic        dec_hit;
  logic [2:0]  dec_sel;
  logic        gnt_sel;
  logic        rv_sel;
  logic [31:0] rdata_sel;
  logic        tmo;

  periph_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .SLV_BASE (SLV_BASE)
  ) u_decode (
    .addr (m_addr[31:12]),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // Only the selected port's handshake is ever looked at.
  always_comb begin
    gnt_sel   = 1'b0;
    rv_sel    = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (sel_q == 3'(i)) begin
        gnt_sel   = s_gnt[i];
        rv_sel    = s_rvalid[i];
        rdata_sel = s_rdata[i*32 +: 32];
      end
    end
  end

  // 9-bit compare so TIMEOUT=255 cannot wrap; this is the last waiting cycle.
  assign tmo = ({1'b0, cnt} + 9'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_nx = state;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_rdata  = '0;
    s_req    = '0;
    case (state)
      ST_IDLE: begin
        if (m_req) state_nx = dec_hit ? ST_REQ : ST_DERR;
      end
      ST_REQ: begin
        for (int unsigned i = 0; i < N_SLAVES; i++) s_req[i] = (sel_q == 3'(i));
        m_gnt = gnt_sel;
        if (gnt_sel)  state_nx = ST_RESP;
        else if (tmo) state_nx = ST_DERR;
      end
      ST_RESP: begin
        m_rvalid = rv_sel;
        m_rdata  = rdata_sel;
        if (rv_sel)   state_nx = ST_IDLE;
        else if (tmo) state_nx = ST_ERESP;
      end
      ST_DERR: begin
        m_gnt    = 1'b1;
        state_nx = ST_ERESP;
      end
      ST_ERESP: begin
        m_rvalid = 1'b1;
        m_err    = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      s_we    <= 1'b0;
      s_be    <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else if (state == ST_REQ || state == ST_RESP)
        cnt <= cnt + 8'd1;
      if (state == ST_IDLE && m_req) begin
        sel_q   <= dec_sel;
        s_we    <= m_we;
        s_be    <= m_be;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
      end
    end
  end

endmodule
